// File: rtl/rip_pkg.sv
// Shared types for the writeback arbiter slice: register index, data word, writeback source.
package rip_pkg;

    typedef logic [4:0]  reg_idx_t;
    typedef logic [31:0] xlen_t;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_PIPE = 2'd1,
        WB_LU   = 2'd2,
        WB_DBG  = 2'd3
    } wb_src_e;

    localparam int unsigned NUM_REGS = 32;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_idx_t idx);
        return {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/rip_wb_arbiter_if.sv
// Writeback arbiter bus bundle. Debug write port signals exist only with RIP_WB_DEBUG_PORT_EN.
interface rip_wb_arbiter_if;
    import rip_pkg::*;

    logic     pipe_wen;
    reg_idx_t pipe_rd;
    xlen_t    pipe_wdata;
    logic     pipe_hold;

    logic     lu_valid;
    reg_idx_t lu_rd;
    xlen_t    lu_wdata;
    logic     lu_ready;

    logic     iss_valid;
    reg_idx_t iss_rd;
    logic     iss_ready;

    reg_idx_t chk_rs1;
    reg_idx_t chk_rs2;
    logic     raw_stall;

    logic     rf_wen;
    reg_idx_t rf_rd;
    xlen_t    rf_wdata;

`ifdef RIP_WB_DEBUG_PORT_EN
    logic     dbg_valid;
    reg_idx_t dbg_rd;
    xlen_t    dbg_wdata;
    logic     dbg_ready;
`endif

    modport master (
        output pipe_wen, pipe_rd, pipe_wdata, lu_valid, lu_rd, lu_wdata,
        output iss_valid, iss_rd, chk_rs1, chk_rs2,
`ifdef RIP_WB_DEBUG_PORT_EN
        output dbg_valid, dbg_rd, dbg_wdata, input dbg_ready,
`endif
        input  pipe_hold, lu_ready, iss_ready, raw_stall, rf_wen, rf_rd, rf_wdata
    );

    modport slave (
        input  pipe_wen, pipe_rd, pipe_wdata, lu_valid, lu_rd, lu_wdata,
        input  iss_valid, iss_rd, chk_rs1, chk_rs2,
`ifdef RIP_WB_DEBUG_PORT_EN
        input  dbg_valid, dbg_rd, dbg_wdata, output dbg_ready,
`endif
        output pipe_hold, lu_ready, iss_ready, raw_stall, rf_wen, rf_rd, rf_wdata
    );

endinterface

// File: rtl/rip_scoreboard.sv
// Pending-destination bitmap and in-flight counter for long-latency ops; gates dispatch and flags RAW hazards.
module rip_scoreboard
    import rip_pkg::*;
#(
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     iss_valid,
    input  reg_idx_t iss_rd,
    input  logic     lu_accept,
    input  reg_idx_t lu_rd,
    input  reg_idx_t chk_rs1,
    input  reg_idx_t chk_rs2,
    output logic     iss_ready,
    output logic     raw_stall
);

    localparam int unsigned OW = $clog2(MAX_OUTST + 1);

    logic [NUM_REGS-1:0] pending_r;
    logic [NUM_REGS-1:0] pending_nxt_s;
    logic [NUM_REGS-1:0] set_mask_s;
    logic [NUM_REGS-1:0] clr_mask_s;
    logic [OW-1:0]       outst_r;
    logic [OW-1:0]       outst_nxt_s;
    logic                waw_s;
    logic                full_s;
    logic                dispatch_s;
    logic                dec_s;

    // Dispatch gate: a retirement in this same cycle frees both its slot and its destination
    always_comb begin
        waw_s  = pending_r[iss_rd] & ~(lu_accept & (lu_rd == iss_rd));
        full_s = (outst_r == OW'(MAX_OUTST)) & ~lu_accept;
        if (rst_n) begin
            iss_ready = ~waw_s & ~full_s;
            raw_stall = pending_r[chk_rs1] | pending_r[chk_rs2];
        end else begin
            iss_ready = 1'b0;
            raw_stall = 1'b0;
        end
    end

    // Next bitmap and counter; set is applied after clear so it wins on the same rd
    always_comb begin
        dispatch_s    = iss_valid & iss_ready;
        dec_s         = lu_accept & (outst_r != OW'(0));
        set_mask_s    = (dispatch_s && (iss_rd != 5'd0)) ? reg_onehot(iss_rd) : {NUM_REGS{1'b0}};
        clr_mask_s    = lu_accept ? reg_onehot(lu_rd) : {NUM_REGS{1'b0}};
        pending_nxt_s = (pending_r & ~clr_mask_s) | set_mask_s;
        case ({dispatch_s, dec_s})
            2'b10:   outst_nxt_s = outst_r + OW'(1);
            2'b01:   outst_nxt_s = outst_r - OW'(1);
            default: outst_nxt_s = outst_r;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_r <= {NUM_REGS{1'b0}};
            outst_r   <= OW'(0);
        end else begin
            pending_r <= pending_nxt_s;
            outst_r   <= outst_nxt_s;
        end
    end

endmodule

// File: rtl/rip_wb_arbiter.sv
// Regfile writeback arbiter: pipe vs long-latency unit with starvation override.
// Optional lowest-priority debug write port under RIP_WB_DEBUG_PORT_EN.
module rip_wb_arbiter
    import rip_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned MAX_OUTST  = 4
) (
    input logic             clk,
    input logic             rst_n,
    rip_wb_arbiter_if.slave bus
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_r;
    logic          starved_s;
    logic          lu_accept_s;
    wb_src_e       grant_s;
    reg_idx_t      sel_rd_s;
    xlen_t         sel_data_s;

    // Grant selection; a starved LU pre-empts the pipe, which is then held
    always_comb begin
        starved_s = bus.lu_valid & (starve_r == SW'(STARVE_MAX));
        if (!rst_n) begin
            grant_s = WB_NONE;
        end else if (starved_s) begin
            grant_s = WB_LU;
        end else if (bus.pipe_wen) begin
            grant_s = WB_PIPE;
        end else if (bus.lu_valid) begin
            grant_s = WB_LU;
`ifdef RIP_WB_DEBUG_PORT_EN
        end else if (bus.dbg_valid) begin
            grant_s = WB_DBG;
`endif
        end else begin
            grant_s = WB_NONE;
        end
        lu_accept_s = bus.lu_valid & (grant_s == WB_LU);
    end

    // Write-port mux and handshakes; rd==0 grants complete without writing
    always_comb begin
        case (grant_s)
            WB_PIPE: begin
                sel_rd_s   = bus.pipe_rd;
                sel_data_s = bus.pipe_wdata;
            end
            WB_LU: begin
                sel_rd_s   = bus.lu_rd;
                sel_data_s = bus.lu_wdata;
            end
`ifdef RIP_WB_DEBUG_PORT_EN
            WB_DBG: begin
                sel_rd_s   = bus.dbg_rd;
                sel_data_s = bus.dbg_wdata;
            end
`endif
            default: begin
                sel_rd_s   = 5'd0;
                sel_data_s = 32'd0;
            end
        endcase
        bus.rf_wen    = (grant_s != WB_NONE) & (sel_rd_s != 5'd0);
        bus.rf_rd     = sel_rd_s;
        bus.rf_wdata  = sel_data_s;
        bus.lu_ready  = lu_accept_s;
        bus.pipe_hold = rst_n & starved_s & bus.pipe_wen;
`ifdef RIP_WB_DEBUG_PORT_EN
        bus.dbg_ready = (grant_s == WB_DBG);
`endif
    end

    // Starvation counter: counts refused LU cycles, clears on accept or idle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_r <= SW'(0);
        end else if (!bus.lu_valid || lu_accept_s) begin
            starve_r <= SW'(0);
        end else if (starve_r != SW'(STARVE_MAX)) begin
            starve_r <= starve_r + SW'(1);
        end else begin
            starve_r <= starve_r;
        end
    end

    rip_scoreboard #(
        .MAX_OUTST (MAX_OUTST)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .iss_valid (bus.iss_valid),
        .iss_rd    (bus.iss_rd),
        .lu_accept (lu_accept_s),
        .lu_rd     (bus.lu_rd),
        .chk_rs1   (bus.chk_rs1),
        .chk_rs2   (bus.chk_rs2),
        .iss_ready (bus.iss_ready),
        .raw_stall (bus.raw_stall)
    );

endmodule

// File: doc/rip_wb_arbiter.md
RIP_WB_ARBITER -- requirements
Module: rip_wb_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: consecutive cycles the long-latency unit (LU) may wait before the pipeline is held.
REQ-002 Parameter MAX_OUTST, default 4: maximum LU operations in flight.
REQ-003 clk  input  1  clock.
REQ-004 rst_n  input  1  reset: synchronous, active-low.
REQ-005 pipe_wen, pipe_rd[4:0], pipe_wdata[31:0]  input  1/5/32  MA-stage writeback; has no backpressure.
REQ-006 pipe_hold  output  1  freezes the MA stage this cycle; the pipe writeback is not consumed.
REQ-007 lu_valid, lu_rd[4:0], lu_wdata[31:0]  input  1/5/32  LU writeback request.
REQ-008 lu_ready  output  1  LU writeback accepted this cycle.
REQ-009 iss_valid, iss_rd[4:0]  input  1/5  dispatch of an LU op targeting iss_rd.
REQ-010 iss_ready  output  1  dispatch permitted.
REQ-011 chk_rs1[4:0], chk_rs2[4:0]  input  5/5  source registers of the instruction in decode.
REQ-012 raw_stall  output  1  a source register is pending in the scoreboard.
REQ-013 rf_wen, rf_rd[4:0], rf_wdata[31:0]  output  1/5/32  regfile write port.
REQ-014 dbg_valid, dbg_rd[4:0], dbg_wdata[31:0]  input  1/5/32, and dbg_ready  output  1: debug write port (present only under REQ-033).

Function
REQ-015 Outputs are combinational from inputs and state; the arbiter adds zero latency.
REQ-016 Priority: LU when starved; otherwise pipe; then LU; then dbg.
- Exactly one grant per cycle.
REQ-017 Starvation counter: increments each cycle lu_valid=1 and lu_ready=0; clears on lu_ready or when lu_valid=0; saturates at STARVE_MAX.
REQ-018 Starved (counter==STARVE_MAX, lu_valid=1): lu_ready=1, and pipe_hold=1 when pipe_wen=1; the counter clears on the next edge.
REQ-019 pipe_hold=0 whenever the LU is not starved.
REQ-020 rf_wen=1 only for the granted source and only when its rd!=0.
- A grant with rd==0 still completes the handshake with no write.
REQ-021 Scoreboard: 32-bit pending bitmap.
- Bit set on an iss_valid&iss_ready edge with iss_rd!=0.
- Bit cleared on an lu_valid&lu_ready edge for lu_rd.
- Bit 0 is never set.
REQ-022 When set and clear target the same rd in one cycle, set wins.
REQ-023 iss_ready=0 if pending[iss_rd]=1 (WAW) or outstanding==MAX_OUTST.
REQ-024 Outstanding counter: +1 on dispatch, -1 on LU accept, net 0 when both occur in one cycle.
- Never exceeds MAX_OUTST; never underflows.
- lu_valid with outstanding==0 is a protocol error, accepted without decrement.
REQ-025 raw_stall = pending[chk_rs1] | pending[chk_rs2], evaluated on the current-cycle state.
- A clear occurring in the same cycle does not suppress raw_stall; the regfile forwarding covers the following read.
REQ-026 dbg_ready=1 only when pipe_wen=0 and lu_valid=0.
- A debug write does not alter the scoreboard.

Reset
REQ-027 While rst_n=0, the following are forced to 0: rf_wen, rf_rd, rf_wdata, lu_ready, dbg_ready, pipe_hold, iss_ready, raw_stall.
REQ-028 On a reset edge, the pending bitmap, the outstanding counter and the starvation counter clear to 0.
REQ-029 Reset asserted mid-operation discards all in-flight LU bookkeeping.
- LU responses arriving after reset are accepted and produce writes, but do not underflow any counter.
REQ-030 First cycle after reset deassertion: iss_ready=1 and raw_stall=0.

Configuration
REQ-031 Macro RIP_WB_DEBUG_PORT_EN controls the debug write port.
REQ-032 Without RIP_WB_DEBUG_PORT_EN, the dbg_* ports do not exist and the arbitration has two sources.
REQ-033 With RIP_WB_DEBUG_PORT_EN, the dbg_* ports exist and arbitrate at lowest priority per REQ-026.

Structure
REQ-034 Shared package rip_pkg holds:
- typedef reg_idx_t (5 bits);
- typedef xlen_t (32 bits);
- enum wb_src_e {WB_NONE, WB_PIPE, WB_LU, WB_DBG}.
REQ-035 One sub-module, rip_scoreboard, holds the pending bitmap, the outstanding counter, iss_ready and raw_stall.
- Grant selection and the starvation counter remain in rip_wb_arbiter.

Verification
REQ-036 Scenario: pipe_wen=1 rd=5 data=0xA5, lu_valid=0 -> rf_wen=1, rf_rd=5, rf_wdata=0xA5, pipe_hold=0.
REQ-037 Scenario: iss rd=7 dispatched, then chk_rs1=7 -> raw_stall=1.
- LU writes rd=7 data=0x1234 -> lu_ready=1, rf_wdata=0x1234; raw_stall=0 next cycle.
REQ-038 Scenario: lu_valid=1 and pipe_wen=1 held for 6 cycles -> lu_ready=0 for cycles 1-4.
- Cycle 5: lu_ready=1, pipe_hold=1.
- Cycle 6: pipe granted.
REQ-039 Scenario: 4 dispatches to rd=1..4 -> iss_ready=0 on the 5th.
- A same-cycle LU accept for rd=1 plus a dispatch to rd=1 -> pending[1]=1, outstanding stays 4.
REQ-040 Scenario: iss rd=0, then LU write rd=0 -> rf_wen=0, lu_ready=1, pending bitmap remains 0.
REQ-041 Scenario: 3 ops outstanding, rst_n=0 for 1 cycle -> all outputs 0 during reset.
- After reset: pending=0, outstanding=0, iss_ready=1.
